// File: rtl/sort_seq_ctrl.sv
// Group sequencer for the two-stage top-k sorter: splits elem_count scores into
// 2^GROUP_SHIFT-element groups, fetches each one and strobes the E1 sort stage.
module sort_seq_ctrl #(
  parameter int Index_Width  = 16,
  parameter int GROUP_SHIFT  = 5,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [Index_Width-1:0] elem_count,
  output logic                   rd_req,
  output logic [Index_Width-1:0] rd_group,
  input  logic                   rd_valid,
  output logic                   sorter_clr,
  output logic                   E1_sort_en,
  output logic [Index_Width-1:0] E1_index_counter,
  output logic                   E1_last_sort,
  output logic                   busy,
  output logic                   done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [Index_Width:0]   num_groups_q, num_groups_d;
  logic [Index_Width-1:0] grp_q, grp_d;
  logic [3:0]             drain_q, drain_d;
  logic                   rd_req_q, rd_req_d;
  logic [Index_Width-1:0] rd_group_q, rd_group_d;
  logic                   sorter_clr_q, sorter_clr_d;
  logic                   sort_en_q, sort_en_d;
  logic [Index_Width-1:0] index_q, index_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [Index_Width-1:0] grp_inc;
  logic                   grp_is_last;
  logic [Index_Width:0]   ng_sum;

  always_comb begin
    grp_inc     = grp_q + Index_Width'(1);
    grp_is_last = ({1'b0, grp_inc} == num_groups_q);
    // Extra top bit keeps the round-up from wrapping at elem_count = all-ones.
    ng_sum      = {1'b0, elem_count} + (Index_Width+1)'((1 << GROUP_SHIFT) - 1);

    state_d      = state_q;
    num_groups_d = num_groups_q;
    grp_d        = grp_q;
    drain_d      = drain_q;
    sorter_clr_d = 1'b0;
    sort_en_d    = 1'b0;
    last_d       = 1'b0;
    index_d      = index_q;
    rd_group_d   = rd_group_q;

    if (state_q != S_IDLE && abort) begin
      state_d      = S_IDLE;
      // An abort during CLR must not stretch the clear pulse already on the wire.
      sorter_clr_d = (state_q != S_CLR);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d      = S_CLR;
            num_groups_d = ng_sum >> GROUP_SHIFT;
            grp_d        = '0;
          end
        end
        S_CLR:   state_d = (num_groups_q == '0) ? S_DONE : S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (rd_valid) begin
            sort_en_d = 1'b1;
            index_d   = grp_inc;
            last_d    = grp_is_last;
            grp_d     = grp_inc;
            if (grp_is_last) begin
              state_d = S_DRAIN;
              drain_d = 4'(DRAIN_CYCLES);
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == 4'd0) state_d = S_DONE;
          else                 drain_d = drain_q - 4'd1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered decodes of the next state so they align with state_q.
    rd_req_d = (state_d == S_ISSUE);
    if (rd_req_d) rd_group_d = grp_d;
    if (state_d == S_CLR) sorter_clr_d = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      num_groups_q <= '0;
      grp_q        <= '0;
      drain_q      <= '0;
      rd_req_q     <= 1'b0;
      rd_group_q   <= '0;
      sorter_clr_q <= 1'b0;
      sort_en_q    <= 1'b0;
      index_q      <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_groups_q <= num_groups_d;
      grp_q        <= grp_d;
      drain_q      <= drain_d;
      rd_req_q     <= rd_req_d;
      rd_group_q   <= rd_group_d;
      sorter_clr_q <= sorter_clr_d;
      sort_en_q    <= sort_en_d;
      index_q      <= index_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_req           = rd_req_q;
  assign rd_group         = rd_group_q;
  assign sorter_clr       = sorter_clr_q;
  assign E1_sort_en       = sort_en_q;
  assign E1_index_counter = index_q;
  assign E1_last_sort     = last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench for sort_seq_ctrl: scenario tasks with a sort-event scoreboard.
module tb_sort_seq_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] elem_count = '0;
  logic        rd_valid = 1'b0;
  logic        rd_req, sorter_clr, E1_sort_en, E1_last_sort, busy, done;
  logic [15:0] rd_group, E1_index_counter;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] idx;
    logic        last;
  } sort_ev_t;

  sort_ev_t exp_q[$];
  sort_ev_t obs_q[$];

  localparam int HMAX = 64;
  logic        clr_h  [HMAX];
  logic        req_h  [HMAX];
  logic [15:0] grp_h  [HMAX];
  logic        busy_h [HMAX];
  logic        done_h [HMAX];
  logic [37:0] all_h  [HMAX];
  int clr_cnt, req_cnt, done_cnt, sen_cnt;

  sort_seq_ctrl #(.Index_Width(16), .GROUP_SHIFT(5), .DRAIN_CYCLES(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .elem_count(elem_count), .rd_req(rd_req), .rd_group(rd_group),
    .rd_valid(rd_valid), .sorter_clr(sorter_clr), .E1_sort_en(E1_sort_en),
    .E1_index_counter(E1_index_counter), .E1_last_sort(E1_last_sort),
    .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic idle(input int n);
    start = 0; abort = 0; rd_valid = 0; sys_rst = 0;
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  // Drives one job; cycle 0 carries start. A buffer model answers each rd_req
  // with rd_valid 'delay' cycles later and pushes the expected sort event.
  task automatic run_job(input logic [15:0] ec, input int delay, input int ncyc,
                         input int abort_at, input int rst_at, input int extra_start_at);
    int ng, mgrp, valid_at;
    bit dead;
    sort_ev_t ev;
    ng = (int'(ec) + 31) / 32;
    mgrp = 0; valid_at = -1; dead = 0;
    exp_q.delete(); obs_q.delete();
    clr_cnt = 0; req_cnt = 0; done_cnt = 0; sen_cnt = 0;
    for (int t = 0; t < HMAX; t++) begin
      clr_h[t] = 0; req_h[t] = 0; grp_h[t] = '0; busy_h[t] = 0; done_h[t] = 0; all_h[t] = '0;
    end
    for (int t = 0; t < ncyc; t++) begin
      start      = (t == 0) || (t == extra_start_at);
      elem_count = ec;
      abort      = (t == abort_at);
      sys_rst    = (t == rst_at);
      rd_valid   = (t == valid_at);
      if (t == abort_at || t == rst_at) dead = 1;
      if (rd_valid && !dead) begin
        mgrp++;
        ev.cyc = 32'(t + 1); ev.idx = 16'(mgrp); ev.last = (mgrp == ng);
        exp_q.push_back(ev);
      end
      @(negedge sys_clk);
      clr_h[t] = sorter_clr; req_h[t] = rd_req; grp_h[t] = rd_group;
      busy_h[t] = busy; done_h[t] = done;
      all_h[t] = {rd_req, sorter_clr, E1_sort_en, E1_last_sort, busy, done, rd_group, E1_index_counter};
      clr_cnt += int'(sorter_clr); req_cnt += int'(rd_req);
      done_cnt += int'(done); sen_cnt += int'(E1_sort_en);
      if (E1_sort_en) begin
        ev.cyc = 32'(t); ev.idx = E1_index_counter; ev.last = E1_last_sort;
        obs_q.push_back(ev);
      end
      if (rd_req) valid_at = t + delay;
      @(posedge sys_clk); #1;
    end
    start = 0; abort = 0; sys_rst = 0; rd_valid = 0;
  endtask

  task automatic test_reset;
    sys_rst = 1;
    repeat (3) begin @(posedge sys_clk); #1; end
    @(negedge sys_clk);
    checks++;
    if ({rd_req, sorter_clr, E1_sort_en, E1_last_sort, busy, done, rd_group, E1_index_counter} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {rd_req, sorter_clr, E1_sort_en, E1_last_sort, busy, done, rd_group, E1_index_counter});
    end
    @(posedge sys_clk); #1;
    idle(2);
  endtask

  task automatic test_two_groups;
    bit busy_ok;
    sort_ev_t e, o;
    run_job(16'd64, 1, 20, -1, -1, -1);
    checks++; if (clr_h[1] !== 1'b1 || clr_cnt != 1) begin failures++; $display("FAIL two_clr at1=%b count=%0d want 1/1", clr_h[1], clr_cnt); end
    checks++; if (req_h[2] !== 1'b1 || grp_h[2] !== 16'd0) begin failures++; $display("FAIL two_req0 req=%b grp=%0d want 1/0", req_h[2], grp_h[2]); end
    checks++; if (req_h[4] !== 1'b1 || grp_h[4] !== 16'd1 || req_cnt != 2) begin failures++; $display("FAIL two_req1 req=%b grp=%0d cnt=%0d want 1/1/2", req_h[4], grp_h[4], req_cnt); end
    checks++; if (done_h[11] !== 1'b1 || done_cnt != 1) begin failures++; $display("FAIL two_done at11=%b count=%0d want 1/1", done_h[11], done_cnt); end
    busy_ok = (busy_h[0] == 1'b0) && (busy_h[12] == 1'b0);
    for (int t = 1; t <= 11; t++) if (busy_h[t] !== 1'b1) busy_ok = 0;
    checks++; if (!busy_ok) begin failures++; $display("FAIL two_busy window got=0 want=1"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL two_sort missing got=none want cyc=%0d idx=%0d last=%b", e.cyc, e.idx, e.last); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL two_sort got cyc=%0d idx=%0d last=%b want cyc=%0d idx=%0d last=%b", o.cyc, o.idx, o.last, e.cyc, e.idx, e.last); end
      end
    end
    checks++; if (sen_cnt != 2) begin failures++; $display("FAIL two_sort_count got=%0d want=2", sen_cnt); end
    idle(2);
  endtask

  task automatic test_group_sizes;
    sort_ev_t e, o;
    logic [15:0] ecs [2] = '{16'd33, 16'd32};
    int want_n [2] = '{2, 1};
    for (int k = 0; k < 2; k++) begin
      run_job(ecs[k], 1, 20, -1, -1, -1);
      checks++; if (sen_cnt != want_n[k]) begin failures++; $display("FAIL size%0d_sort_count got=%0d want=%0d", ecs[k], sen_cnt, want_n[k]); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin failures++; $display("FAIL size%0d_sort missing want idx=%0d", ecs[k], e.idx); end
        else begin
          o = obs_q.pop_front();
          if (o !== e) begin failures++; $display("FAIL size%0d_sort got cyc=%0d idx=%0d last=%b want cyc=%0d idx=%0d last=%b", ecs[k], o.cyc, o.idx, o.last, e.cyc, e.idx, e.last); end
        end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL size%0d_done count=%0d want=1", ecs[k], done_cnt); end
      idle(2);
    end
  endtask

  task automatic test_zero;
    run_job(16'd0, 1, 10, -1, -1, -1);
    checks++; if (clr_h[1] !== 1'b1 || done_h[2] !== 1'b1) begin failures++; $display("FAIL zero_timing clr1=%b done2=%b want 1/1", clr_h[1], done_h[2]); end
    checks++; if (req_cnt != 0 || sen_cnt != 0 || done_cnt != 1) begin failures++; $display("FAIL zero_counts req=%0d sort=%0d done=%0d want 0/0/1", req_cnt, sen_cnt, done_cnt); end
    idle(2);
  endtask

  task automatic test_slow_valid;
    bit busy_ok;
    sort_ev_t e, o;
    run_job(16'd96, 5, 32, -1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL slow_sort missing want idx=%0d", e.idx); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL slow_sort got cyc=%0d idx=%0d last=%b want cyc=%0d idx=%0d last=%b", o.cyc, o.idx, o.last, e.cyc, e.idx, e.last); end
      end
    end
    checks++; if (sen_cnt != 3) begin failures++; $display("FAIL slow_sort_count got=%0d want=3", sen_cnt); end
    busy_ok = 1;
    for (int t = 1; t <= 25; t++) if (busy_h[t] !== 1'b1) busy_ok = 0;
    checks++; if (!busy_ok || done_h[25] !== 1'b1) begin failures++; $display("FAIL slow_busy_done busy_ok=%0d done25=%b want 1/1", busy_ok, done_h[25]); end
    idle(2);
  endtask

  task automatic test_abort;
    sort_ev_t e, o;
    run_job(16'd64, 3, 20, 8, -1, -1);
    checks++; if (clr_h[9] !== 1'b1 || clr_cnt != 2) begin failures++; $display("FAIL abort_clr at9=%b count=%0d want 1/2", clr_h[9], clr_cnt); end
    checks++; if (done_cnt != 0 || busy_h[9] !== 1'b0) begin failures++; $display("FAIL abort_state done=%0d busy9=%b want 0/0", done_cnt, busy_h[9]); end
    checks++; if (sen_cnt != 1 || exp_q.size() != 1) begin failures++; $display("FAIL abort_sort_count got=%0d want=1", sen_cnt); end
    idle(2);
    run_job(16'd32, 1, 14, -1, -1, -1);
    checks++; if (done_h[9] !== 1'b1 || done_cnt != 1) begin failures++; $display("FAIL post_abort_done at9=%b count=%0d want 1/1", done_h[9], done_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL post_abort_sort missing want idx=%0d", e.idx); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL post_abort_sort got cyc=%0d idx=%0d last=%b want cyc=%0d idx=%0d last=%b", o.cyc, o.idx, o.last, e.cyc, e.idx, e.last); end
      end
    end
    idle(2);
  endtask

  task automatic test_reset_in_drain;
    run_job(16'd64, 1, 20, -1, 7, -1);
    checks++; if (all_h[8] !== 38'd0) begin failures++; $display("FAIL rst_drain_outputs got=%h want=0", all_h[8]); end
    checks++; if (done_cnt != 0 || busy_h[12] !== 1'b0) begin failures++; $display("FAIL rst_drain_done count=%0d busy12=%b want 0/0", done_cnt, busy_h[12]); end
    idle(2);
  endtask

  task automatic test_start_while_busy;
    bit idle_ok;
    run_job(16'd64, 1, 22, -1, -1, 3);
    checks++; if (done_cnt != 1 || done_h[11] !== 1'b1 || req_cnt != 2) begin failures++; $display("FAIL busy_start done=%0d done11=%b req=%0d want 1/1/2", done_cnt, done_h[11], req_cnt); end
    idle_ok = 1;
    for (int t = 12; t < 22; t++) if (busy_h[t] !== 1'b0) idle_ok = 0;
    checks++; if (!idle_ok) begin failures++; $display("FAIL busy_start_queued busy after done got=1 want=0"); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_two_groups();
    test_group_sizes();
    test_zero();
    test_slow_valid();
    test_abort();
    test_reset_in_drain();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
